// File: rtl/vmc_multi_item_if.sv
// Front-panel and actuator signals of the vending controller, grouped as one bus.
// The master side is the panel/coin acceptor. The slave side is the controller.
interface vmc_if #(
  parameter int N_ITEMS = 3,
  parameter int BAL_W   = 8,
  parameter int STOCK_W = 4
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic               start;
  logic               select;
  logic               ok;
  logic               cancel;
  logic               coin_1;
  logic               coin_5;
  logic               coin_10;
  logic               restock;
  logic [IDX_W-1:0]   restock_item;
  logic [STOCK_W-1:0] restock_qty;

  logic [N_ITEMS-1:0] item;
  logic [N_ITEMS-1:0] sold_out;
  logic [BAL_W-1:0]   balance;
  logic               dispense;
  logic               c1;
  logic               c5;
  logic               c10;
  logic               coin_reject;
  logic               busy;

  modport master (
    output start, select, ok, cancel, coin_1, coin_5, coin_10,
           restock, restock_item, restock_qty,
    input  item, sold_out, balance, dispense, c1, c5, c10, coin_reject, busy
  );

  modport slave (
    input  start, select, ok, cancel, coin_1, coin_5, coin_10,
           restock, restock_item, restock_qty,
    output item, sold_out, balance, dispense, c1, c5, c10, coin_reject, busy
  );
endinterface

// File: rtl/vmc_multi_item.sv
// Multi-item vending controller: per-item price and stock, payment timeout, greedy change.
// State updates on the falling clock edge. DISPENSE follows the accepting OK edge by one cycle.
module vmc_multi_item #(
  parameter int                         N_ITEMS    = 3,
  parameter int                         BAL_W      = 8,
  parameter int                         STOCK_W    = 4,
  parameter logic [N_ITEMS*BAL_W-1:0]   PRICES     = {8'd12, 8'd5, 8'd3},
  parameter int                         INIT_STOCK = 5,
  parameter int                         TIMEOUT    = 200
) (
  input logic  clk,
  input logic  rst,
  vmc_if.slave bus
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_PAY, S_DISP, S_CHG} state_t;

  state_t                            state, state_nxt;
  logic [IDX_W-1:0]                  ptr, ptr_nxt;
  logic [BAL_W-1:0]                  balance, bal_nxt;
  logic [BAL_W-1:0]                  change_due, due_nxt;
  logic [TMR_W-1:0]                  timer, timer_nxt;
  logic [N_ITEMS-1:0][STOCK_W-1:0]   stock, stock_nxt;
  logic                              reject_q, rej_nxt;

  logic start_q, select_q, ok_q, coin1_q, coin5_q, coin10_q;
  logic start_e, select_e, ok_e, coin1_e, coin5_e, coin10_e;

  logic [N_ITEMS-1:0][BAL_W-1:0] price_tab;
  logic [BAL_W-1:0]              price_cur;
  logic [BAL_W-1:0]              coin_val;
  logic [BAL_W:0]                coin_sum;
  logic                          coin_any, coin_fits, coin_extra;
  logic [BAL_W-1:0]              chg_coin;
  logic                          timed_out;
  logic                          any_stock;
  logic [IDX_W-1:0]              low_idx;
  logic [IDX_W-1:0]              nxt_idx;
  logic [IDX_W-1:0]              cand;
  logic                          found;
  logic                          restock_in_range;
  logic [STOCK_W:0]              rs_sum;

  assign start_e  = bus.start   & ~start_q;
  assign select_e = bus.select  & ~select_q;
  assign ok_e     = bus.ok      & ~ok_q;
  assign coin1_e  = bus.coin_1  & ~coin1_q;
  assign coin5_e  = bus.coin_5  & ~coin5_q;
  assign coin10_e = bus.coin_10 & ~coin10_q;

  assign price_tab = PRICES;
  assign price_cur = price_tab[ptr];

  // Only the highest-priority coin (1 > 5 > 10) is a credit candidate.
  assign coin_any   = coin1_e | coin5_e | coin10_e;
  assign coin_val   = coin1_e ? BAL_W'(1) : coin5_e ? BAL_W'(5) : coin10_e ? BAL_W'(10) : '0;
  assign coin_extra = coin1_e ? (coin5_e | coin10_e) : (coin5_e & coin10_e);
  assign coin_sum   = {1'b0, balance} + {1'b0, coin_val};
  assign coin_fits  = coin_any && (balance < price_cur) && !coin_sum[BAL_W];

  assign chg_coin  = (change_due >= BAL_W'(10)) ? BAL_W'(10) :
                     (change_due >= BAL_W'(5))  ? BAL_W'(5)  :
                     (change_due != '0)         ? BAL_W'(1)  : '0;
  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  assign restock_in_range = (int'(bus.restock_item) < N_ITEMS);

  always_comb begin
    rs_sum = '0;
    if (restock_in_range)
      rs_sum = {1'b0, stock[bus.restock_item]} + {1'b0, bus.restock_qty};
  end

  always_comb begin
    any_stock = 1'b0;
    low_idx   = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (stock[IDX_W'(i)] != '0) begin
        any_stock = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
  end

  // Search upward from ptr with wrap; ptr itself is the last candidate.
  always_comb begin
    nxt_idx = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_ITEMS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_ITEMS);
      if (!found && stock[cand] != '0) begin
        found   = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    bal_nxt   = balance;
    due_nxt   = change_due;
    timer_nxt = timer;
    stock_nxt = stock;
    rej_nxt   = coin_any;
    case (state)
      S_IDLE: begin
        if (bus.restock && restock_in_range)
          stock_nxt[bus.restock_item] = rs_sum[STOCK_W] ? '1 : rs_sum[STOCK_W-1:0];
        if (start_e && any_stock) begin
          ptr_nxt   = low_idx;
          state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        if (bus.cancel) begin
          state_nxt = S_IDLE;
        end else if (ok_e) begin
          state_nxt = S_PAY;
          timer_nxt = '0;
        end else if (select_e) begin
          ptr_nxt = nxt_idx;
        end
      end
      S_PAY: begin
        if (bus.cancel || timed_out) begin
          due_nxt   = balance;
          bal_nxt   = '0;
          timer_nxt = '0;
          state_nxt = (balance == '0) ? S_IDLE : S_CHG;
        end else if (ok_e && balance >= price_cur) begin
          timer_nxt = '0;
          state_nxt = S_DISP;
        end else begin
          timer_nxt = ok_e ? '0 : timer + TMR_W'(1);
          if (coin_fits) begin
            bal_nxt   = coin_sum[BAL_W-1:0];
            timer_nxt = '0;
            rej_nxt   = coin_extra;
          end
        end
      end
      S_DISP: begin
        stock_nxt[ptr] = stock[ptr] - STOCK_W'(1);
        due_nxt        = balance - price_cur;
        bal_nxt        = '0;
        state_nxt      = S_CHG;
      end
      S_CHG: begin
        if (change_due == '0) state_nxt = S_IDLE;
        else                  due_nxt   = change_due - chg_coin;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      balance    <= '0;
      change_due <= '0;
      timer      <= '0;
      reject_q   <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
      start_q    <= 1'b0;
      select_q   <= 1'b0;
      ok_q       <= 1'b0;
      coin1_q    <= 1'b0;
      coin5_q    <= 1'b0;
      coin10_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      balance    <= bal_nxt;
      change_due <= due_nxt;
      timer      <= timer_nxt;
      reject_q   <= rej_nxt;
      stock      <= stock_nxt;
      start_q    <= bus.start;
      select_q   <= bus.select;
      ok_q       <= bus.ok;
      coin1_q    <= bus.coin_1;
      coin5_q    <= bus.coin_5;
      coin10_q   <= bus.coin_10;
    end
  end

  assign bus.item = (state == S_SEL || state == S_PAY) ? (N_ITEMS'(1) << ptr) : '0;

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) bus.sold_out[i] = (stock[i] == '0);
  end

  assign bus.balance     = balance;
  assign bus.dispense    = (state == S_DISP);
  assign bus.c10         = (state == S_CHG) && (chg_coin == BAL_W'(10));
  assign bus.c5          = (state == S_CHG) && (chg_coin == BAL_W'(5));
  assign bus.c1          = (state == S_CHG) && (chg_coin == BAL_W'(1));
  assign bus.coin_reject = reject_q;
  assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_vmc_multi_item.sv
// Directed table-driven bench for vmc_multi_item with hand sequences for multi-cycle cases.
// Inputs change just after the rising edge; the DUT updates on the falling edge.
module tb_vmc_multi_item;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  vmc_if #(.N_ITEMS(3), .BAL_W(8), .STOCK_W(4)) bus ();

  vmc_multi_item dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input vector bits: {start, select, ok, cancel, coin_1, coin_5, coin_10}
  localparam logic [6:0] I0  = 7'b0000000;
  localparam logic [6:0] ST  = 7'b1000000;
  localparam logic [6:0] SL  = 7'b0100000;
  localparam logic [6:0] OK  = 7'b0010000;
  localparam logic [6:0] CN  = 7'b0001000;
  localparam logic [6:0] K1  = 7'b0000100;
  localparam logic [6:0] K5  = 7'b0000010;
  localparam logic [6:0] K10 = 7'b0000001;
  // pulse bits: {dispense, c10, c5, c1}
  localparam logic [3:0] PN  = 4'b0000;
  localparam logic [3:0] PD  = 4'b1000;
  localparam logic [3:0] P5  = 4'b0010;
  localparam logic [3:0] P1  = 4'b0001;

  typedef struct {
    string      nm;
    logic [6:0] in;
    logic [2:0] e_item;
    logic [7:0] e_bal;
    logic [3:0] e_pulse;
    logic       e_rej;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [6:0] v);
    {bus.start, bus.select, bus.ok, bus.cancel, bus.coin_1, bus.coin_5, bus.coin_10} = v;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.dispense, bus.c10, bus.c5, bus.c1};
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      step(I0);
      n++;
    end
    chk(nm, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c1_cnt;
    int d_cnt;
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    {bus.start, bus.select, bus.ok, bus.cancel, bus.coin_1, bus.coin_5, bus.coin_10} = I0;
    bus.restock      = 1'b0;
    bus.restock_item = '0;
    bus.restock_qty  = '0;

    // {name, inputs, item, balance, pulses, reject, busy}
    vq.push_back('{"t1 idle",     I0,  3'b000, 8'd0,  PN, 1'b0, 1'b0});
    vq.push_back('{"t1 start",    ST,  3'b001, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t1 ok",       OK,  3'b001, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t1 coin5",    K5,  3'b001, 8'd5,  PN, 1'b0, 1'b1});
    vq.push_back('{"t1 ok pay",   OK,  3'b000, 8'd5,  PD, 1'b0, 1'b1});
    vq.push_back('{"t1 chg a",    I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t1 chg b",    I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t1 chg end",  I0,  3'b000, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t1 back",     I0,  3'b000, 8'd0,  PN, 1'b0, 1'b0});
    vq.push_back('{"idle coin",   K1,  3'b000, 8'd0,  PN, 1'b1, 1'b0});
    vq.push_back('{"idle quiet",  I0,  3'b000, 8'd0,  PN, 1'b0, 1'b0});
    vq.push_back('{"t2 start",    ST,  3'b001, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 sel a",    SL,  3'b010, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 sel low",  I0,  3'b010, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 sel b",    SL,  3'b100, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 ok",       OK,  3'b100, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 coin10 a", K10, 3'b100, 8'd10, PN, 1'b0, 1'b1});
    vq.push_back('{"t2 low",      I0,  3'b100, 8'd10, PN, 1'b0, 1'b1});
    vq.push_back('{"t2 ok short", OK,  3'b100, 8'd10, PN, 1'b0, 1'b1});
    vq.push_back('{"t2 low2",     I0,  3'b100, 8'd10, PN, 1'b0, 1'b1});
    vq.push_back('{"t2 coin10 b", K10, 3'b100, 8'd20, PN, 1'b0, 1'b1});
    vq.push_back('{"t2 ok pay",   OK,  3'b000, 8'd20, PD, 1'b0, 1'b1});
    vq.push_back('{"t2 chg c5",   I0,  3'b000, 8'd0,  P5, 1'b0, 1'b1});
    vq.push_back('{"t2 chg c1a",  I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t2 chg c1b",  I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t2 chg c1c",  I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t2 chg end",  I0,  3'b000, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t2 back",     I0,  3'b000, 8'd0,  PN, 1'b0, 1'b0});
    vq.push_back('{"t5 start",    ST,  3'b001, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 ok",       OK,  3'b001, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 dual",     K1 | K10, 3'b001, 8'd1, PN, 1'b1, 1'b1});
    vq.push_back('{"t5 low0",     I0,  3'b001, 8'd1,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 coin5",    K5,  3'b001, 8'd6,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 low1",     I0,  3'b001, 8'd6,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 coin10",   K10, 3'b001, 8'd6,  PN, 1'b1, 1'b1});
    vq.push_back('{"t5 cancel",   CN,  3'b000, 8'd0,  P5, 1'b0, 1'b1});
    vq.push_back('{"t5 chg c1",   I0,  3'b000, 8'd0,  P1, 1'b0, 1'b1});
    vq.push_back('{"t5 chg end",  I0,  3'b000, 8'd0,  PN, 1'b0, 1'b1});
    vq.push_back('{"t5 back",     I0,  3'b000, 8'd0,  PN, 1'b0, 1'b0});

    #2;
    chk("reset busy",     {31'd0, bus.busy}, 32'd0);
    chk("reset balance",  {24'd0, bus.balance}, 32'd0);
    chk("reset pulses",   {28'd0, pulses()}, 32'd0);
    chk("reset sold_out", {29'd0, bus.sold_out}, 32'd0);
    chk("reset stock0",   {28'd0, dut.stock[0]}, 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].in);
      chk({vq[i].nm, " item"},   {29'd0, bus.item},        {29'd0, vq[i].e_item});
      chk({vq[i].nm, " bal"},    {24'd0, bus.balance},     {24'd0, vq[i].e_bal});
      chk({vq[i].nm, " pulses"}, {28'd0, pulses()},        {28'd0, vq[i].e_pulse});
      chk({vq[i].nm, " reject"}, {31'd0, bus.coin_reject}, {31'd0, vq[i].e_rej});
      chk({vq[i].nm, " busy"},   {31'd0, bus.busy},        {31'd0, vq[i].e_busy});
    end
    chk("stock0 after buys", {28'd0, dut.stock[0]}, 32'd4);
    chk("stock2 after buys", {28'd0, dut.stock[2]}, 32'd4);

    // Sell out item 1 (price 5) with exact payment.
    for (int b = 0; b < 5; b++) begin
      step(ST);
      step(SL);
      step(OK);
      step(K5);
      step(OK);
      chk("drain dispense", {31'd0, bus.dispense}, 32'd1);
      wait_idle("drain idle");
    end
    chk("t3 sold_out", {29'd0, bus.sold_out}, 32'b010);
    step(ST);
    chk("t3 start item", {29'd0, bus.item}, 32'b001);
    step(SL);
    chk("t3 skip item1", {29'd0, bus.item}, 32'b100);
    step(I0);
    step(SL);
    chk("t3 wrap item0", {29'd0, bus.item}, 32'b001);
    step(CN);
    chk("t3 cancel idle", {31'd0, bus.busy}, 32'd0);

    // Cancel with one coin credited refunds exactly one C1.
    step(ST);
    step(OK);
    step(K1);
    chk("t4 bal", {24'd0, bus.balance}, 32'd1);
    step(CN);
    c1_cnt = 0;
    d_cnt  = 0;
    n      = 0;
    while (bus.busy && n < 20) begin
      c1_cnt += int'(bus.c1);
      d_cnt  += int'(bus.dispense);
      step(I0);
      n++;
    end
    chk("t4 refund c1", c1_cnt, 32'd1);
    chk("t4 no dispense", d_cnt, 32'd0);
    chk("t4 idle", {31'd0, bus.busy}, 32'd0);

    // No coins: PAY lasts TIMEOUT cycles, then IDLE.
    step(ST);
    step(OK);
    n = 0;
    while (bus.busy && n < 1000) begin
      step(I0);
      n++;
    end
    chk("t4 timeout cycles", n, 32'd200);

    // Mid-change reset, then restock saturation and out-of-range index.
    step(ST);
    step(SL);
    chk("t6 item2", {29'd0, bus.item}, 32'b100);
    step(OK);
    step(K10);
    step(I0);
    step(K10);
    step(OK);
    chk("t6 dispense", {31'd0, bus.dispense}, 32'd1);
    step(I0);
    chk("t6 in chg c5", {31'd0, bus.c5}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 rst busy",    {31'd0, bus.busy}, 32'd0);
    chk("t6 rst pulses",  {28'd0, pulses()}, 32'd0);
    chk("t6 rst balance", {24'd0, bus.balance}, 32'd0);
    chk("t6 rst item",    {29'd0, bus.item}, 32'd0);
    chk("t6 rst reject",  {31'd0, bus.coin_reject}, 32'd0);
    chk("t6 rst stock1",  {28'd0, dut.stock[1]}, 32'd5);
    chk("t6 rst stock2",  {28'd0, dut.stock[2]}, 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.restock      = 1'b1;
    bus.restock_item = 2'd0;
    bus.restock_qty  = 4'd15;
    step(I0);
    chk("t6 restock sat", {28'd0, dut.stock[0]}, 32'd15);
    bus.restock_item = 2'd3;
    bus.restock_qty  = 4'd1;
    step(I0);
    chk("t6 oor stock0", {28'd0, dut.stock[0]}, 32'd15);
    chk("t6 oor stock2", {28'd0, dut.stock[2]}, 32'd5);
    bus.restock_item = 2'd1;
    bus.restock_qty  = 4'd2;
    step(I0);
    chk("t6 restock add", {28'd0, dut.stock[1]}, 32'd7);
    bus.restock = 1'b0;
    step(I0);
    chk("t6 final busy", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
